// File: rtl/bridge_pkg.sv
// bridge_pkg: shared state encoding, default address map and sizing helper for the bridge
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam int          DEF_N_SLAVES    = 3;
    localparam logic [95:0] DEF_BASE_ADDRS  = {32'h0000_7F10, 32'h0000_7F00, 32'h0000_0000};
    localparam logic [95:0] DEF_LIMIT_ADDRS = {32'h0000_7F1B, 32'h0000_7F0B, 32'h0000_2FFF};
    localparam logic [2:0]  DEF_WORD_ONLY   = 3'b110;
    localparam int          DEF_TIMEOUT     = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/bridge_addr_decoder.sv
// bridge_addr_decoder: maps a byte address to a one-hot slave select and flags illegal write sizes
module bridge_addr_decoder
    import bridge_pkg::*;
#(
    parameter int                      N_SLAVES    = DEF_N_SLAVES,
    parameter logic [N_SLAVES*32-1:0]  BASE_ADDRS  = DEF_BASE_ADDRS,
    parameter logic [N_SLAVES*32-1:0]  LIMIT_ADDRS = DEF_LIMIT_ADDRS,
    parameter logic [N_SLAVES-1:0]     WORD_ONLY   = DEF_WORD_ONLY
) (
    input  logic [31:0]         addr,
    input  logic [3:0]          byteen,
    output logic [N_SLAVES-1:0] sel_onehot,
    output logic                hit,
    output logic                illegal
);

    // Scan from the highest index down so the lowest matching window has the final say
    always_comb begin
        sel_onehot = '0;
        hit        = 1'b0;
        illegal    = 1'b0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (addr >= BASE_ADDRS[i*32 +: 32] && addr <= LIMIT_ADDRS[i*32 +: 32]) begin
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                hit           = 1'b1;
                illegal       = WORD_ONLY[i] && byteen != 4'h0 && byteen != 4'hF;
            end
        end
    end

endmodule

// File: rtl/multi_slave_bridge.sv
// multi_slave_bridge: CPU-to-peripheral bridge with windowed decode, req/ack handshake and timeout
module multi_slave_bridge
    import bridge_pkg::*;
#(
    parameter int                      N_SLAVES    = DEF_N_SLAVES,
    parameter logic [N_SLAVES*32-1:0]  BASE_ADDRS  = DEF_BASE_ADDRS,
    parameter logic [N_SLAVES*32-1:0]  LIMIT_ADDRS = DEF_LIMIT_ADDRS,
    parameter logic [N_SLAVES-1:0]     WORD_ONLY   = DEF_WORD_ONLY,
    parameter int                      TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_req,
    input  logic [31:0]            cpu_addr,
    input  logic [3:0]             cpu_byteen,
    input  logic [31:0]            cpu_wdata,
    output logic                   cpu_ready,
    output logic                   cpu_err,
    output logic [31:0]            cpu_rdata,
    output logic [N_SLAVES-1:0]    s_req,
    output logic [31:0]            s_addr,
    output logic [3:0]             s_byteen,
    output logic [31:0]            s_wdata,
    input  logic [N_SLAVES*32-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]    s_ack
);

    localparam int CW = clog2(TIMEOUT);

    state_t                state, state_nx;
    logic [CW-1:0]         cnt;
    logic [N_SLAVES-1:0]   sel_onehot;
    logic                  hit, illegal;
    logic                  accept, ack, timed_out;
    logic [31:0]           rd_mux;

    bridge_addr_decoder #(
        .N_SLAVES    (N_SLAVES),
        .BASE_ADDRS  (BASE_ADDRS),
        .LIMIT_ADDRS (LIMIT_ADDRS),
        .WORD_ONLY   (WORD_ONLY)
    ) u_dec (
        .addr       (cpu_addr),
        .byteen     (cpu_byteen),
        .sel_onehot (sel_onehot),
        .hit        (hit),
        .illegal    (illegal)
    );

    // A request held through the completion pulse belongs to the finished transaction, so skip that cycle
    assign accept    = state == IDLE && cpu_req && !cpu_ready;
    assign ack       = |(s_ack & s_req);
    assign timed_out = cnt == CW'(TIMEOUT - 1);

    // Read data of the channel currently being served; s_req is one-hot during WAIT
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_SLAVES; i++)
            rd_mux = rd_mux | (s_req[i] ? s_rdata[i*32 +: 32] : 32'h0);
    end

    // Next-state selection; ack beats a simultaneous timeout
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? ((hit && !illegal) ? WAIT : ERR) : IDLE;
            WAIT:    state_nx = ack ? RESP : (timed_out ? ERR : WAIT);
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Slave-side latches, timeout counter and registered CPU response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
            s_req     <= '0;
            s_addr    <= '0;
            s_byteen  <= '0;
            s_wdata   <= '0;
        end else begin
            cpu_ready <= state == RESP || state == ERR;
            cpu_err   <= state == ERR;
            if (accept && hit && !illegal) begin
                s_req    <= sel_onehot;
                s_addr   <= cpu_addr;
                s_byteen <= cpu_byteen;
                s_wdata  <= cpu_wdata;
                cnt      <= '0;
            end
            if (state == WAIT) begin
                if (ack) begin
                    s_req     <= '0;
                    cpu_rdata <= (s_byteen == 4'h0) ? rd_mux : 32'h0;
                end else if (timed_out) begin
                    s_req <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (state == ERR) cpu_rdata <= '0;
        end
    end

endmodule

// File: tb/tb_multi_slave_bridge.sv
// tb_multi_slave_bridge: randomized transactions against a window/latency reference model
module tb_multi_slave_bridge;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_byteen;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic [31:0] cpu_rdata;
    logic [2:0]  s_req;
    logic [31:0] s_addr;
    logic [3:0]  s_byteen;
    logic [31:0] s_wdata;
    logic [95:0] s_rdata;
    logic [2:0]  s_ack;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_rdata = 32'h0;

    int unsigned base_a  [3] = '{32'h0000_0000, 32'h0000_7F00, 32'h0000_7F10};
    int unsigned limit_a [3] = '{32'h0000_2FFF, 32'h0000_7F0B, 32'h0000_7F1B};
    bit          word_a  [3] = '{1'b0, 1'b1, 1'b1};
    int unsigned edges_a [10] = '{32'h0, 32'h2FFF, 32'h3000, 32'h7EFF, 32'h7F00,
                                  32'h7F0B, 32'h7F0C, 32'h7F1B, 32'h7F1C, 32'hFFFF_FFFF};

    multi_slave_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_byteen (cpu_byteen),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_err    (cpu_err),
        .cpu_rdata  (cpu_rdata),
        .s_req      (s_req),
        .s_addr     (s_addr),
        .s_byteen   (s_byteen),
        .s_wdata    (s_wdata),
        .s_rdata    (s_rdata),
        .s_ack      (s_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Lowest-numbered window containing the address wins; -1 when nothing matches
    task automatic model_decode(input logic [31:0] a, input logic [3:0] be, output int sel, output bit err);
        sel = -1;
        for (int i = 2; i >= 0; i--)
            if (a >= base_a[i] && a <= limit_a[i]) sel = i;
        err = sel < 0 || (word_a[sel] && be != 4'h0 && be != 4'hF);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, cpu_ready, 0);
        check({tag, "_err"}, cpu_err, 0);
        check({tag, "_rdata"}, cpu_rdata, 0);
        check({tag, "_sreq"}, s_req, 0);
        check({tag, "_saddr"}, s_addr, 0);
        check({tag, "_sbyteen"}, s_byteen, 0);
        check({tag, "_swdata"}, s_wdata, 0);
    endtask

    // Called at a falling edge; drives one request as a stalled CPU would and plays the selected slave
    task automatic run_txn(input string tag, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd, input int d, input logic [31:0] data);
        int sel, e, n_sreq, exp_lat, exp_n;
        bit derr, exp_err, done;
        logic [31:0] exp_rdata;
        model_decode(a, be, sel, derr);
        if (derr) begin
            exp_err = 1; exp_lat = 1; exp_n = 0; exp_rdata = 0;
        end else if (d <= TIMEOUT - 1) begin
            exp_err = 0; exp_lat = d + 2; exp_n = d + 1; exp_rdata = (be == 4'h0) ? data : 32'h0;
        end else begin
            exp_err = 1; exp_lat = TIMEOUT + 1; exp_n = TIMEOUT; exp_rdata = 0;
        end
        check({tag, "_rdata_hold"}, cpu_rdata, last_rdata);
        cpu_req = 1; cpu_addr = a; cpu_byteen = be; cpu_wdata = wd;
        e = -1; n_sreq = 0; done = 0;
        while (!done && e < 40) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            cpu_addr = $urandom; cpu_byteen = 4'($urandom); cpu_wdata = $urandom;
            if (s_req != 0) begin
                n_sreq++;
                if (n_sreq == 1) begin
                    check({tag, "_sreq"}, s_req, (sel >= 0) ? (32'd1 << sel) : 32'd0);
                    check({tag, "_saddr"}, s_addr, a);
                    check({tag, "_sbyteen"}, s_byteen, be);
                    check({tag, "_swdata"}, s_wdata, wd);
                end
            end
            if (cpu_ready) begin
                check({tag, "_latency"}, e, exp_lat);
                check({tag, "_err"}, cpu_err, exp_err);
                check({tag, "_rdata"}, cpu_rdata, exp_rdata);
                check({tag, "_sreq_cycles"}, n_sreq, exp_n);
                done = 1;
                cpu_req = 0;
            end
            s_ack = 3'($urandom);
            s_rdata = {$urandom, $urandom, $urandom};
            if (sel >= 0 && s_req != 0) begin
                s_ack[sel] = (n_sreq == d + 1);
                s_rdata[sel*32 +: 32] = data;
            end
        end
        check({tag, "_completed"}, done, 1);
        last_rdata = exp_rdata;
        @(negedge clk);
        check({tag, "_ready_pulse"}, cpu_ready, 0);
        s_ack = 0;
    endtask

    initial begin
        reset = 0; cpu_req = 0; cpu_addr = 0; cpu_byteen = 0; cpu_wdata = 0;
        s_rdata = 0; s_ack = 0;
        #1;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);

        run_txn("dm_read", 32'h0000_0100, 4'h0, 32'h0, 0, 32'hDEAD_BEEF);
        run_txn("io_write", 32'h0000_7F04, 4'hF, 32'hCAFE_0001, 5, 32'h1111_2222);
        run_txn("unmapped", 32'h0000_5000, 4'h0, 32'h0, 0, 32'h3333_4444);
        run_txn("illegal_size", 32'h0000_7F10, 4'h3, 32'h5555_6666, 0, 32'h7777_8888);
        run_txn("timeout", 32'h0000_0200, 4'h0, 32'h0, 99, 32'h9999_AAAA);
        run_txn("ack_at_limit", 32'h0000_0204, 4'h0, 32'h0, TIMEOUT - 1, 32'h0BAD_F00D);

        cpu_req = 1; cpu_addr = 32'h0000_0300; cpu_byteen = 4'h0; cpu_wdata = 0;
        repeat (4) @(negedge clk);
        check("midwait_sreq", s_req, 3'b001);
        reset = 0;
        #1;
        check_outputs_zero("midreset");
        cpu_req = 0;
        @(negedge clk);
        reset = 1;
        s_ack = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_ack_ready", cpu_ready, 0);
            check("late_ack_sreq", s_req, 0);
        end
        s_ack = 0;
        last_rdata = 0;
        @(negedge clk);
        run_txn("after_reset", 32'h0000_7F18, 4'h0, 32'h0, 2, 32'h1234_5678);

        for (int k = 0; k < 60; k++) begin
            logic [31:0] a;
            logic [3:0]  be;
            int          d, w;
            case ($urandom_range(0, 2))
                0: begin
                    w = $urandom_range(0, 2);
                    a = base_a[w] + $urandom_range(0, limit_a[w] - base_a[w]);
                end
                1: a = edges_a[$urandom_range(0, 9)];
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 2))
                0: be = 4'h0;
                1: be = 4'hF;
                default: be = 4'($urandom);
            endcase
            d = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 4);
            run_txn("rand", a, be, $urandom, d, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
